// File: rtl/srl32_seq.sv
// Multi-cycle right shifter for srl/sra: shifts one bit per clock
// under a start/busy/done handshake; shamt taken from B[10:6].
module srl32_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        arith,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] res
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]  state;
  logic [31:0] sh;
  logic [4:0]  cnt;
  logic        fill;

  // Only the shamt field of the instruction word matters.
  logic unused_b;
  assign unused_b = ^{B[31:11], B[5:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      fill  <= 1'b0;
      res   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= SHIFT;
            sh    <= A;
            cnt   <= B[10:6];
            fill  <= arith & A[31];
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          if (cnt == 5'd0) begin
            state <= DONE;
            res   <= sh;
          end else begin
            sh  <= {fill, sh[31:1]};
            cnt <= cnt - 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_srl32_seq.sv
// Self-checking bench for srl32_seq: vector table plus handshake,
// back-to-back and reset corner sequences, scoreboarded on done.
module tb_srl32_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        arith = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy;
  logic        done;
  logic [31:0] res;

  srl32_seq dut (
    .clk(clk), .rst(rst), .start(start), .arith(arith),
    .A(A), .B(B), .busy(busy), .done(done), .res(res)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ar;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } sb_t;

  sb_t sb[$];
  vec_t vecs[10];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and score any done pulse there.
  task automatic step();
    sb_t e;
    @(negedge clk);
    if (!rst) begin
      if (busy && done) chk("busy_and_done", 1'b1, 1'b0);
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("res", res, e.res);
          chk("latency", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk({name, "_timeout"}, 1'b0, 1'b1);
  endtask

  // Called just after a falling edge: request on the next rising edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic ar, input logic [31:0] exp,
                       input int lat);
    A = a;
    B = b;
    arith = ar;
    start = 1'b1;
    sb.push_back('{res: exp, cyc: cyc + 1 + lat});
  endtask

  initial begin
    int d0;
    vecs[0] = '{32'h80000000, 32'h00000100, 1'b0, 32'h08000000, 5};
    vecs[1] = '{32'h80000000, 32'h00000100, 1'b1, 32'hF8000000, 5};
    vecs[2] = '{32'h7FFFFFF0, 32'h00000100, 1'b1, 32'h07FFFFFF, 5};
    vecs[3] = '{32'hDEADBEEF, 32'h00000000, 1'b0, 32'hDEADBEEF, 1};
    vecs[4] = '{32'h80000000, 32'h000007C0, 1'b1, 32'hFFFFFFFF, 32};
    vecs[5] = '{32'h80000000, 32'h000007C0, 1'b0, 32'h00000001, 32};
    vecs[6] = '{32'h12345678, 32'hFFFFF83F, 1'b0, 32'h12345678, 1};
    vecs[7] = '{32'hDEADBEEF, 32'h00000000, 1'b1, 32'hDEADBEEF, 1};
    vecs[8] = '{32'hF0000000, 32'h00000200, 1'b1, 32'hFFF00000, 9};
    vecs[9] = '{32'h12345678, 32'h00000400, 1'b0, 32'h00001234, 17};

    step();
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_res", res, 32'h0);
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].ar, vecs[i].exp, vecs[i].lat);
      step();
      start = 1'b0;
      chk($sformatf("busy_v%0d", i), busy, 1'b1);
      wait_done($sformatf("v%0d", i));
      step();
    end

    // Start pulse and operand changes mid-shift must be ignored.
    d0 = done_cnt;
    issue(32'h80000000, 32'h00000100, 1'b1, 32'hF8000000, 5);
    step();
    start = 1'b0;
    A = 32'h0;
    B = 32'hFFFFFFFF;
    arith = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("ignore");
    for (int i = 0; i < 40; i++) step();
    chk("ignore_one_done", 32'(done_cnt - d0), 32'd1);

    // Back-to-back: start held through DONE.
    issue(32'h80000000, 32'h00000100, 1'b0, 32'h08000000, 5);
    wait_done("b2b_first");
    issue(32'h00000010, 32'h00000040, 1'b0, 32'h00000008, 2);
    step();
    chk("b2b_busy_no_gap", busy, 1'b1);
    start = 1'b0;
    wait_done("b2b_second");
    step();

    // Reset three cycles into a shamt=10 shift aborts it.
    d0 = done_cnt;
    A = 32'hFFFF0000;
    B = 32'h00000280;
    arith = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_res", res, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_res_held", res, 32'h0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/srl32_seq.md
# srl32_seq

Multi-cycle logical/arithmetic right shifter. It is the right-shift counterpart of the single-cycle left shifter and serves the datapath's `srl`/`sra` instructions. Shift amount comes from the instruction shamt field `B[10:6]`. The operand is shifted one bit per clock under a start/busy/done handshake, so the ALU result mux can stall on `busy` and capture `res` on `done`.

## Interface
- No parameters; datapath width fixed at 32, shamt width fixed at 5.
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when not busy.
- `arith`  in  1  1 = arithmetic (sign-fill, `sra`), 0 = logical (zero-fill, `srl`); captured with `start`.
- `A`  in  32  operand to shift; captured with `start`.
- `B`  in  32  instruction word; only `B[10:6]` (shamt) used, captured with `start`; other bits ignored.
- `busy`  out  1  high while a shift is in progress.
- `done`  out  1  one-cycle pulse: `res` valid.
- `res`  out  32  result; holds last result until next accepted `start`.

## Operation
- Internal state: 32-bit work register `sh`, 5-bit down-counter `cnt`, sign bit `fill`, states IDLE, SHIFT, DONE.
- IDLE:
  - On `start`=1, load `sh`=A, `cnt`=B[10:6], `fill`=arith & A[31].
  - Go to SHIFT; `busy`=1.
- SHIFT:
  - If `cnt`=0: go to DONE, `res`=`sh`, `done`=1, `busy`=0.
  - Else: `sh` = {fill, sh[31:1]} and `cnt`=cnt−1.
- DONE:
  - Lasts exactly one cycle; `done`=1.
  - Behaves as IDLE for `start`: a new request is accepted in this cycle and proceeds to SHIFT; otherwise return to IDLE.
- `start` while in SHIFT is ignored. It is not queued and captured operands are unaffected.
- Changes on `A`, `B`, `arith` after the accept edge have no effect.
- Result equals `A >> shamt` (logical) or `$signed(A) >>> shamt` (arithmetic), for shamt 0..31.

## Timing
- Reset values: `busy`=0, `done`=0, `res`=0x00000000, state IDLE, `sh`=0, `cnt`=0.
- `rst` has priority over all other inputs in every state.
- Reset mid-shift aborts the operation. No `done` is produced and `res` returns to 0.
- Accept edge is E0. `busy` is high in the cycles after E0 through E(shamt+1). `done` is high for the single cycle after edge E(shamt+1).
- Latency: shamt+1 cycles from accept to `done`. shamt=0 gives 1 cycle; shamt=31 gives 32 cycles.
- `busy` and `done` are never both high.
- `res` changes only on the edge that raises `done` (or on reset).
- Back-to-back: `start` held high through DONE is accepted there. `busy` then rises the next cycle with no idle gap.

## Test plan
- Logical shift: A=0x80000000, B=0x00000100 (shamt=4), arith=0 → `done` 5 cycles after accept, `res`=0x08000000.
- Arithmetic shift: same A and shamt, arith=1 → `res`=0xF8000000. Positive case: A=0x7FFFFFF0, arith=1, shamt=4 → `res`=0x07FFFFFF.
- Boundaries:
  - shamt=0, A=0xDEADBEEF → `res`=0xDEADBEEF with `done` 1 cycle after accept.
  - shamt=31, A=0x80000000, arith=1 → `res`=0xFFFFFFFF after 32 cycles.
  - shamt=31, arith=0 → `res`=0x00000001.
- Field isolation: B=0xFFFFF83F (shamt=0 with every other bit set), A=0x12345678 → `res`=0x12345678. Changing A/B during SHIFT does not alter the result.
- Handshake:
  - `start` pulsed while busy is ignored; only one `done`.
  - `start` held through DONE with new A=0x00000010, shamt=1 → second `done` 2 cycles later with `res`=0x00000008.
- Reset: assert `rst` 3 cycles into a shamt=10 shift → next cycle `busy`=0, `done`=0, `res`=0; no `done` follows.
